// File: rtl/calc_display_scan.sv
// Time-multiplexed 7-segment scanner for the calculator result.
// Holds a tear-free shown value and renders one digit per slot with PWM dimming.
package calc_pkg;
  localparam int NumDigits = 8;

  function automatic logic [6:0] bcd2segments(input logic [3:0] bcd);
    case (bcd)
      4'd0:    bcd2segments = 7'b1111110;
      4'd1:    bcd2segments = 7'b0110000;
      4'd2:    bcd2segments = 7'b1101101;
      4'd3:    bcd2segments = 7'b1111001;
      4'd4:    bcd2segments = 7'b0110011;
      4'd5:    bcd2segments = 7'b1011011;
      4'd6:    bcd2segments = 7'b1011111;
      4'd7:    bcd2segments = 7'b1110000;
      4'd8:    bcd2segments = 7'b1111111;
      default: bcd2segments = 7'b1111011;
    endcase
  endfunction
endpackage

module calc_display_scan #(
  parameter int NumDigits = calc_pkg::NumDigits,
  parameter int ClkDiv    = 1000,
  parameter int DimBits   = 4,
  localparam int ExpW     = $clog2(NumDigits),
  localparam int NumW     = 2 + ExpW + 4*NumDigits
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumW-1:0]      num_i,
  input  logic                 load_i,
  input  logic [DimBits-1:0]   brightness_i,
  output logic [NumDigits-1:0] anodes_o,
  output logic [6:0]           segments_o,
  output logic                 dp_o,
  output logic                 frame_o
);
  localparam int SlotW = $clog2(ClkDiv);
  localparam logic [6:0] SegE     = 7'b1001111;
  localparam logic [6:0] SegMinus = 7'b0000001;

  logic [SlotW-1:0] slot_cnt;
  logic [ExpW-1:0]  digit_idx;
  logic [NumW-1:0]  pending, shown;
  logic             pend_vld;
  logic             slot_wrap, boundary;

  assign slot_wrap = (slot_cnt == SlotW'(ClkDiv-1));
  assign boundary  = slot_wrap && (digit_idx == ExpW'(NumDigits-1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (slot_wrap) digit_idx <= boundary ? '0 : digit_idx + 1'b1;
    end
  end

  // A load in the boundary cycle bypasses pending so it lands in this frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending  <= '0;
      pend_vld <= 1'b0;
      shown    <= '0;
    end else if (boundary) begin
      if (load_i)        shown <= num_i;
      else if (pend_vld) shown <= pending;
      pend_vld <= 1'b0;
    end else if (load_i) begin
      pending  <= num_i;
      pend_vld <= 1'b1;
    end
  end

  logic [4*NumDigits-1:0] sig;
  logic [ExpW-1:0]        expo, msd, top;
  logic                   sign, err, neg, bad, lit;
  logic [3:0]             cur_bcd;
  logic [6:0]             seg_d;
  logic                   dp_d;
  logic [NumDigits-1:0]   an_d;

  assign sig  = shown[4*NumDigits-1:0];
  assign expo = shown[4*NumDigits +: ExpW];
  assign err  = shown[NumW-2];
  assign sign = shown[NumW-1];

  always_comb begin
    msd = '0;
    for (int k = 0; k < NumDigits; k++)
      if (sig[4*k +: 4] != 4'd0) msd = ExpW'(k);
  end

  assign top     = (msd > expo) ? msd : expo;
  // Negative zero renders as plain zero, so the minus needs a nonzero significand.
  assign neg     = sign && (|sig);
  assign bad     = err || (neg && top == ExpW'(NumDigits-1));
  assign cur_bcd = sig[4*digit_idx +: 4];
  assign lit     = (&brightness_i) ||
                   (32'(slot_cnt) < ((ClkDiv * 32'(brightness_i)) >> DimBits));

  always_comb begin
    seg_d = 7'b0000000;
    if (bad) begin
      if (digit_idx == '0) seg_d = SegE;
    end else if (digit_idx <= top) begin
      seg_d = calc_pkg::bcd2segments(cur_bcd);
    end else if (neg && ({1'b0, digit_idx} == {1'b0, top} + 1'b1)) begin
      seg_d = SegMinus;
    end
  end

  assign dp_d = !bad && (digit_idx == expo) && (expo != '0);
  assign an_d = lit ? (NumDigits'(1) << digit_idx) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      anodes_o   <= '0;
      segments_o <= '0;
      dp_o       <= 1'b0;
      frame_o    <= 1'b0;
    end else begin
      anodes_o   <= an_d;
      segments_o <= seg_d;
      dp_o       <= dp_d;
      frame_o    <= (slot_cnt == '0) && (digit_idx == '0);
    end
  end
endmodule

// File: tb/tb_calc_display_scan.sv
// Self-checking bench for calc_display_scan: directed corner cases plus random
// loads/brightness against a frame-position reference model.
module tb_calc_display_scan;
  localparam int ND = 8, CD = 4, DB = 4, EW = 3, NW = 2 + EW + 4*ND, FL = ND*CD;
  localparam logic [6:0] SEG [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                       7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                       7'b1111111, 7'b1111011};

  logic          gclk = 1'b0;
  logic          grst_n = 1'b0;
  logic [NW-1:0] num = '0;
  logic          load = 1'b0;
  logic [DB-1:0] bright = 4'd15;
  logic [ND-1:0] anodes;
  logic [6:0]    segments;
  logic          dp, frame;

  calc_display_scan #(.NumDigits(ND), .ClkDiv(CD), .DimBits(DB)) dut (
    .clk_i(gclk), .rst_ni(grst_n), .num_i(num), .load_i(load), .brightness_i(bright),
    .anodes_o(anodes), .segments_o(segments), .dp_o(dp), .frame_o(frame)
  );

  always #5 gclk = ~gclk;

  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: position within the frame plus the value on screen.
  int            pos = 0;
  logic [NW-1:0] m_shown = '0, m_pend = '0;
  bit            m_pv = 0;

  function automatic logic [NW-1:0] mk(input bit s, input bit e, input int x, input logic [31:0] sg);
    mk = {s, e, x[EW-1:0], sg};
  endfunction

  // {dp, segments} for display column i of value v.
  function automatic logic [7:0] glyph(input logic [NW-1:0] v, input int i);
    logic [31:0] sg;
    int x, hi, width, need, d;
    bit neg, show_err;
    sg = v[31:0];
    x  = int'(v[32 +: EW]);
    hi = 0;
    for (int k = 0; k < ND; k++) if (((sg >> (4*k)) & 32'hF) != 0) hi = k;
    width    = ((hi > x) ? hi : x) + 1;
    neg      = v[NW-1] && (sg != 0);
    need     = width + (neg ? 1 : 0);
    show_err = v[NW-2] || (need > ND);
    if (show_err) return {1'b0, (i == 0) ? 7'b1001111 : 7'b0000000};
    d = int'((sg >> (4*i)) & 32'hF);
    glyph[7] = (x != 0) && (i == x);
    if (i < width)             glyph[6:0] = SEG[(d > 9) ? 9 : d];
    else if (neg && i == width) glyph[6:0] = 7'b0000001;
    else                        glyph[6:0] = 7'b0000000;
  endfunction

  // Called at posedge+1: drive inputs, advance one clock, compare.
  task automatic cyc(input bit ld, input logic [NW-1:0] n);
    logic [7:0]    g;
    logic [ND-1:0] e_an;
    bit            e_fr;
    int            slot, dig;
    load = ld; num = n;
    @(posedge gclk);
    dig  = pos / CD;
    slot = pos % CD;
    g    = glyph(m_shown, dig);
    e_an = ((bright == 4'd15) || (slot < (CD*int'(bright))/16)) ? ND'(1) << dig : '0;
    e_fr = (pos == 0);
    if (pos == FL-1) begin
      if (ld) m_shown = n;
      else if (m_pv) m_shown = m_pend;
      m_pv = 0;
    end else if (ld) begin
      m_pend = n; m_pv = 1;
    end
    pos = (pos + 1) % FL;
    #1;
    chk("anodes", 32'(anodes), 32'(e_an));
    chk("segments", 32'(segments), 32'(g[6:0]));
    chk("dp", 32'(dp), 32'(g[7]));
    chk("frame", 32'(frame), 32'(e_fr));
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0);
  endtask

  task automatic do_reset();
    grst_n = 1'b0;
    #1;
    chk("rst_anodes", 32'(anodes), 0);
    chk("rst_segments", 32'(segments), 0);
    chk("rst_dp", 32'(dp), 0);
    chk("rst_frame", 32'(frame), 0);
    repeat (2) @(posedge gclk);
    #1;
    grst_n = 1'b1;
    pos = 0; m_shown = '0; m_pend = '0; m_pv = 0;
  endtask

  initial begin
    logic [31:0] sg;
    @(posedge gclk);
    #1;
    do_reset();
    idle(40);
    while (pos != 10) idle(1);
    cyc(1, mk(1, 0, 2, 32'h0000_1234));
    idle(70);
    cyc(1, mk(0, 0, 3, 32'h0000_0005));
    idle(FL + 8);
    cyc(1, mk(0, 1, 5, $urandom));
    idle(FL + 8);
    cyc(1, mk(1, 0, 0, 32'h9000_0000));
    idle(FL + 8);
    cyc(1, mk(0, 0, 1, 32'h00AB_0C07));
    idle(FL + 8);
    bright = 4'd4; idle(40);
    bright = 4'd0; idle(40);
    bright = 4'd15;
    while (pos != FL-1) idle(1);
    cyc(1, mk(0, 0, 0, 32'h0000_0042));
    idle(FL + 4);
    while (pos != 5) idle(1);
    cyc(1, mk(0, 0, 0, 32'h0000_0111));
    idle(3);
    cyc(1, mk(1, 0, 1, 32'h0000_0222));
    idle(2*FL);
    cyc(1, mk(1, 0, 0, 32'h0000_0000));
    idle(2*FL);
    cyc(1, mk(0, 0, 4, 32'h0000_0987));
    idle(6);
    do_reset();
    idle(2*FL);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 49) == 0) bright = 4'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        sg = $urandom;
        sg = sg >> (4*$urandom_range(0, 7));
        cyc(1, mk($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7), sg));
      end else begin
        cyc(0, '0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/calc_display_scan.md
# calc_display_scan

Time-multiplexed 7-segment scanner for the calculator's `num_t` result. It sits between the arithmetic datapath and the physical common-anode display. Features:
- Parametrised digit count, refresh rate and PWM brightness.
- Tear-free updates: a new value is applied only at frame boundaries.
- Leading-zero blanking, decimal point placement, a minus sign, and an error glyph.

## Interface
Clock and reset: one clock; reset is asynchronous and active-low.

Parameters:
- `NumDigits`, default `calc_pkg::NumDigits` (8): number of display digits, ≥2.
- `ClkDiv`, default 1000: clock cycles per digit slot, ≥2.
- `DimBits`, default 4: brightness resolution.

Ports (`ExpW` = `$clog2(NumDigits)`):
- `clk_i` in 1: clock.
- `rst_ni` in 1: async active-low reset.
- `num_i` in `2+ExpW+4*NumDigits`: value to display, packed like `num_t` as `{sign, error, exponent, significand}`. Significand digit 0 is least significant.
- `load_i` in 1: capture `num_i` into the pending register this cycle.
- `brightness_i` in `DimBits`: duty level. 0 = dark, all-ones = full.
- `anodes_o` out `NumDigits`: one-hot-or-zero digit enable, active-high. Bit i drives digit i (bit 0 is rightmost).
- `segments_o` out 7: `{a,b,c,d,e,f,g}` with bit6 = a. Encoding is identical to `calc_pkg::bcd2segments`.
- `dp_o` out 1: decimal point for the active digit.
- `frame_o` out 1: one-cycle pulse at each frame start.

## Operation
**Registers**
- `pending`: written by `load_i`. When `load_i` is asserted on several cycles, the last write wins.
- `shown`: updated only at a frame boundary.
- `slot_cnt`: counts 0..ClkDiv-1.
- `digit_idx`: counts 0..NumDigits-1.

**Counters and frame boundary**
- `slot_cnt` increments every cycle.
- On wrap, `digit_idx` increments. It wraps from NumDigits-1 to 0.
- The frame boundary is the cycle in which `digit_idx` wraps to 0.
- At the boundary:
  - If a pending load exists, `shown <= pending`.
  - If `load_i` is asserted in the boundary cycle itself, that cycle's `num_i` goes directly into `shown`.

**Per-digit decode (digit i = `digit_idx`, from `shown`)**
- `msd` = index of the highest nonzero significand digit, or 0 if none.
- `top` = max(`msd`, exponent).
- Glyph selection, in priority order:
  - error=1: digit 0 shows E (`1001111`); all other digits are blank; `dp_o`=0.
  - i ≤ top: `bcd2segments(significand[i])`. BCD values above 9 show the 9 pattern, as the package does.
  - i == top+1 and sign=1: minus (`0000001`).
  - Otherwise: blank (`0000000`).
- Negative value with `top == NumDigits-1`: no room for the minus, so the whole frame shows the error glyph.
- `dp_o` = 1 when i == exponent and exponent ≠ 0 and error = 0.
- The value "negative zero" displays as `0` with no minus.

**Brightness**
- The anode is enabled when `brightness_i` is all-ones, or when `slot_cnt < (ClkDiv*brightness_i) >> DimBits`.
- When the anode is not enabled, `anodes_o` = 0.
- `segments_o` and `dp_o` remain valid during the whole slot.
- `brightness_i` is sampled every cycle; there is no frame alignment.

## Timing
- All outputs are registered. Each output reflects the counter state of the previous cycle, so latency is 1 cycle.
- During reset:
  - `anodes_o`=0, `segments_o`=0, `dp_o`=0, `frame_o`=0.
  - Counters = 0.
  - `shown` = +0 with error=0 and exponent=0.
  - Pending cleared.
- First cycle after reset release: counters start at 0. On the next cycle `anodes_o[0]` asserts (if brightness > 0) showing `0`, and `frame_o` pulses.
- `frame_o` asserts in the cycle after every boundary, simultaneous with the first slot's outputs for digit 0 of the new value.
- Reset asserted mid-frame: all outputs go to 0 asynchronously; any pending load is lost.
- Frame length = `NumDigits*ClkDiv` cycles. A load waits at most one frame before being displayed.

## Test plan
(NumDigits=8, ClkDiv=4, DimBits=4, brightness=15 unless stated)
- Reset, then idle: anode sequence 0x01, 0x02, …, 0x80, each held 4 cycles. Digit 0 shows `1111110`; digits 1–7 show `0000000`. `frame_o` pulses every 32 cycles.
- Load significand 0x00001234, exponent 2, sign 1 mid-frame:
  - No change until the next `frame_o`.
  - Then digits 0–3 show 4, 3, 2, 1 and digit 4 shows `0000001`.
  - `dp_o`=1 only on digit 2; digits 5–7 are blank.
- Load 0x00000005 with exponent 3: digits 0–3 show 5, 0, 0, 0, so zeros are kept up to the decimal point. `dp_o` on digit 3.
- Error cases, each must give E on digit 0 and blank elsewhere:
  - error=1 with any significand.
  - sign=1 with significand 0x90000000.
- Brightness 4: `anodes_o` high for `(4*4)>>4` = 1 cycle of each 4-cycle slot. Brightness 0: `anodes_o` always 0 while `segments_o` still cycles.
- Timing edge cases:
  - `load_i` in the exact boundary cycle: the new value is shown in that frame.
  - Two loads within one frame: only the second is shown.
  - `rst_ni` low mid-slot: outputs are 0 immediately.
